// File: rtl/booth_multiplier_param.sv
// -----------------------------------------------------------------------------
// booth_multiplier_param
//
// Pipelined radix-4 Booth multiplier for signed or unsigned operands, selected
// per transaction. One input-register stage is followed by WIDTH/2+1
// accumulate stages, each adding exactly one Booth partial product, so a
// result appears WIDTH/2+2 cycles after acceptance. The pipeline accepts one
// transaction per cycle and freezes as a whole while a result waits at the
// output.
//
// Optional feature macro: BOOTH_MULTIPLIER_TAG_EN
//   When defined, a TAG_W-bit sideband tag travels with each transaction.
//   When undefined, no tag ports and no tag registers exist.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (drops all in-flight work)
//   x, y         multiplicand / multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   in_valid     x/y/signed_mode (and in_tag) valid this cycle
//   in_ready     block accepts an input this cycle
//   result       2*WIDTH-bit product
//   out_valid    result valid
//   out_ready    downstream accepts result
//   in_tag       (tag build only) tag captured on acceptance
//   out_tag      (tag build only) tag aligned with result/out_valid
// -----------------------------------------------------------------------------
module booth_multiplier_param #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  input  logic               out_ready
`ifdef BOOTH_MULTIPLIER_TAG_EN
  ,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag
`endif
);

  // Number of Booth digits / partial products for a WIDTH+2-bit multiplier.
  localparam int NPP = WIDTH / 2 + 1;
  localparam int PW  = 2 * WIDTH;
  // Extended multiplier plus the implicit zero below bit 0.
  localparam int YW  = WIDTH + 3;

  if ((WIDTH % 2) != 0 || WIDTH < 4 || TAG_W < 1) begin : g_param_check
    $error("booth_multiplier_param: WIDTH must be even and >= 4, TAG_W >= 1");
  end

  // Valid bits for the input stage (0) and the NPP accumulate stages.
  logic            vld_q  [NPP+1];
  logic            vld_d  [NPP+1];
  // Operand stages 0..NPP-1 feed the adder of the following stage.
  logic            mode_q [NPP];
  logic            mode_d [NPP];
  logic [WIDTH-1:0] x_q   [NPP];
  logic [WIDTH-1:0] x_d   [NPP];
  logic [YW-1:0]   y_q    [NPP];
  logic [YW-1:0]   y_d    [NPP];
  // acc_q[k] holds the sum of the first k+1 partial products.
  logic [PW-1:0]   acc_q  [NPP];
  logic [PW-1:0]   acc_d  [NPP];
`ifdef BOOTH_MULTIPLIER_TAG_EN
  logic [TAG_W-1:0] tag_q [NPP+1];
  logic [TAG_W-1:0] tag_d [NPP+1];
`endif

  logic          advance;
  logic [2:0]    digit;
  logic [PW-1:0] x_wide;
  logic [PW-1:0] mag;
  logic [PW-1:0] pp;
  logic [PW-1:0] acc_in;

  // Next-state for the whole pipeline. Everything holds unless the output is
  // free (advance); bubbles move along like real transactions. The multiplier
  // is pre-shifted by one position so each stage reads its Booth triplet
  // {y[2i+1], y[2i], y[2i-1]} from bits [2:0] and passes y>>2 onward.
  // Partial products are summed modulo 2^(2*WIDTH); because the exact product
  // always fits, the wrap-around is harmless for both signed and unsigned.
  always_comb begin
    advance  = !(vld_q[NPP] && !out_ready);
    in_ready = rst || advance;
    digit    = '0;
    x_wide   = '0;
    mag      = '0;
    pp       = '0;
    acc_in   = '0;

    for (int i = 0; i <= NPP; i++) begin
      vld_d[i] = vld_q[i];
`ifdef BOOTH_MULTIPLIER_TAG_EN
      tag_d[i] = tag_q[i];
`endif
    end
    for (int i = 0; i < NPP; i++) begin
      mode_d[i] = mode_q[i];
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      acc_d[i]  = acc_q[i];
    end

    if (advance) begin
      vld_d[0]  = in_valid;
      mode_d[0] = signed_mode;
      x_d[0]    = x;
      y_d[0]    = {{2{signed_mode & y[WIDTH-1]}}, y, 1'b0};
`ifdef BOOTH_MULTIPLIER_TAG_EN
      tag_d[0]  = in_tag;
`endif

      for (int k = 1; k <= NPP; k++) begin
        vld_d[k] = vld_q[k-1];
`ifdef BOOTH_MULTIPLIER_TAG_EN
        tag_d[k] = tag_q[k-1];
`endif
      end

      for (int k = 1; k < NPP; k++) begin
        mode_d[k] = mode_q[k-1];
        x_d[k]    = x_q[k-1];
        y_d[k]    = y_q[k-1] >> 2;
      end

      for (int k = 0; k < NPP; k++) begin
        x_wide = mode_q[k] ? {{WIDTH{x_q[k][WIDTH-1]}}, x_q[k]}
                           : {{WIDTH{1'b0}}, x_q[k]};
        digit  = y_q[k][2:0];
        case (digit)
          3'b001, 3'b010: mag = x_wide;
          3'b011, 3'b100: mag = x_wide << 1;
          3'b101, 3'b110: mag = x_wide;
          default:        mag = '0;
        endcase
        pp     = digit[2] ? -mag : mag;
        pp     = pp << (2 * k);
        acc_in = (k == 0) ? '0 : acc_q[(k > 0) ? k - 1 : 0];
        acc_d[k] = acc_in + pp;
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NPP; i++) begin
        vld_q[i] <= 1'b0;
`ifdef BOOTH_MULTIPLIER_TAG_EN
        tag_q[i] <= '0;
`endif
      end
      for (int i = 0; i < NPP; i++) begin
        mode_q[i] <= 1'b0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i <= NPP; i++) begin
        vld_q[i] <= vld_d[i];
`ifdef BOOTH_MULTIPLIER_TAG_EN
        tag_q[i] <= tag_d[i];
`endif
      end
      for (int i = 0; i < NPP; i++) begin
        mode_q[i] <= mode_d[i];
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  assign result    = acc_q[NPP-1];
  assign out_valid = vld_q[NPP];
`ifdef BOOTH_MULTIPLIER_TAG_EN
  assign out_tag   = tag_q[NPP];
`endif

endmodule

// File: tb/tb_booth_multiplier_param.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier_param
//
// Scoreboard bench for booth_multiplier_param (WIDTH=8). Accepted inputs push
// their expected product (plain integer multiplication) into a queue; a
// monitor running alongside pops and compares whenever a result leaves.
// -----------------------------------------------------------------------------
module tb_booth_multiplier_param;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int LAT   = WIDTH / 2 + 2;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               signed_mode;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] result;
  logic               out_valid;
  logic               out_ready;
`ifdef BOOTH_MULTIPLIER_TAG_EN
  logic [TAG_W-1:0]   in_tag;
  logic [TAG_W-1:0]   out_tag;
`endif

  booth_multiplier_param #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .signed_mode(signed_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef BOOTH_MULTIPLIER_TAG_EN
    ,
    .in_tag     (in_tag),
    .out_tag    (out_tag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*WIDTH-1:0] res;
    logic [TAG_W-1:0]   tag;
    int                 cyc;
    bit                 chkLat;
  } exp_t;

  exp_t sb[$];
  int assertions = 0;
  int failures   = 0;

  function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic sm);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    return p[2*WIDTH-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Present one input for one cycle; record it only if the DUT takes it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sm, input logic [TAG_W-1:0] t,
                               input bit v, input bit chkLat);
    exp_t e;
    x = a; y = b; signed_mode = sm; in_valid = v;
`ifdef BOOTH_MULTIPLIER_TAG_EN
    in_tag = t;
`endif
    @(negedge clk);
    if (v && in_ready && !rst) begin
      e.res = refProduct(a, b, sm);
      e.tag = t;
      e.cyc = cyc;
      e.chkLat = chkLat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  // Output side: pop on every handshake, check held values during stalls.
  task automatic monitorLoop();
    bit                 prevStall = 0;
    logic [2*WIDTH-1:0] prevResult = '0;
    logic [TAG_W-1:0]   prevTag = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 0;
      end else begin
        if (prevStall) begin
          checkOutput("stall_hold_valid", out_valid, 1);
          checkOutput("stall_hold_result", result, prevResult);
`ifdef BOOTH_MULTIPLIER_TAG_EN
          checkOutput("stall_hold_tag", out_tag, prevTag);
`endif
        end
        if (out_valid && !out_ready)
          checkOutput("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output (cycle %0d)",
                     result, cyc);
          end else begin
            e = sb.pop_front();
            checkOutput("result", result, e.res);
`ifdef BOOTH_MULTIPLIER_TAG_EN
            checkOutput("out_tag", out_tag, e.tag);
`endif
            if (e.chkLat)
              checkOutput("latency", cyc - e.cyc, LAT);
          end
        end
        prevStall  = out_valid && !out_ready;
        prevResult = result;
`ifdef BOOTH_MULTIPLIER_TAG_EN
        prevTag    = out_tag;
`endif
      end
    end
  endtask

  logic [WIDTH-1:0] bx [6];
  logic [WIDTH-1:0] by [6];

  initial begin
    rst = 1'b1; x = '0; y = '0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef BOOTH_MULTIPLIER_TAG_EN
    in_tag = '0;
`endif
    fork
      monitorLoop();
      begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    // Reset: inputs offered during reset must vanish.
    @(posedge clk); #1;
    x = 8'h12; y = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_during_reset", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    @(negedge clk);
    checkOutput("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed corner products with latency check.
    applyStimulus(8'hFF, 8'h80, 1'b1, 4'h1, 1, 1);
    waitDrain("drain_first", 20);
    applyStimulus(8'h80, 8'h80, 1'b1, 4'h2, 1, 1);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 4'h3, 1, 1);
    applyStimulus(8'h8F, 8'hFF, 1'b0, 4'h4, 1, 1);
    applyStimulus(8'h00, 8'hA5, 1'b1, 4'h5, 1, 1);
    applyStimulus(8'h7F, 8'h7F, 1'b1, 4'h6, 1, 1);
    waitDrain("drain_directed", 20);

    // Six back-to-back with alternating mode; fixed latency implies
    // consecutive-cycle delivery.
    bx[0] = 8'hDF; by[0] = 8'h60;
    bx[1] = 8'h12; by[1] = 8'h34;
    bx[2] = 8'h81; by[2] = 8'h7F;
    bx[3] = 8'hC3; by[3] = 8'hFE;
    bx[4] = 8'h80; by[4] = 8'h01;
    bx[5] = 8'hFF; by[5] = 8'h02;
    for (int i = 0; i < 6; i++)
      applyStimulus(bx[i], by[i], (i % 2) == 0, TAG_W'(i + 1), 1, 1);
    waitDrain("drain_b2b", 20);

    // Stall for three cycles while results are waiting.
    for (int i = 0; i < 6; i++)
      applyStimulus(by[i], bx[i], (i % 2) == 1, TAG_W'(i + 1), 1, 0);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(8'h55, 8'h55, 1'b0, 4'hF, 1, 0);
    out_ready = 1'b1;
    waitDrain("drain_stall", 30);

    // Reset with four transactions in flight.
    for (int i = 0; i < 4; i++)
      applyStimulus(bx[i], by[i], 1'b1, TAG_W'(i + 7), 1, 0);
    rst = 1'b1; x = 8'h77; y = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_mid_reset", in_ready, 1);
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_result", result, 0);
`ifdef BOOTH_MULTIPLIER_TAG_EN
    checkOutput("midreset_out_tag", out_tag, 0);
`endif
    repeat (12) begin
      @(posedge clk); #1;
    end
    checkOutput("no_stale_out_valid", out_valid, 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)),
                    $urandom_range(0, 9) < 7, 0);
    end
    out_ready = 1'b1;
    waitDrain("drain_random", 60);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
